// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbitrated, shared 16-iteration double-dabble binary-to-BCD converter.
// Optional macro BCD_OVF_SAT_EN: saturate bcd_out to 16'h9999 on overflow.
module bcd_conv_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [16*N_REQ-1:0]    bin_in,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [15:0]            bcd_out,
    output logic                   ovf
);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   win_q, win_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [35:0]       sh_q, sh_d;
    logic              done_q, done_d;
    logic [ID_W-1:0]   done_id_q, done_id_d;
    logic [15:0]       bcd_q, bcd_d;
    logic              ovf_q, ovf_d;

    logic              found;
    logic [ID_W-1:0]   pick;
    logic [ID_W-1:0]   idx;
    logic [15:0]       pick_val;
    logic [35:0]       adj;
    logic [35:0]       shifted;

    // Search starts one past the last winner so every pending requester is reached in turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(ptr_q) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        pick_val = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick == ID_W'(i)) pick_val = bin_in[16*i +: 16];
        end
    end

    always_comb begin
        adj = sh_q;
        for (int d = 0; d < 5; d++) begin
            if (sh_q[16+4*d +: 4] >= 4'd5) adj[16+4*d +: 4] = sh_q[16+4*d +: 4] + 4'd3;
        end
        shifted = {adj[34:0], 1'b0};
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        done_d    = done_q;
        done_id_d = done_id_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    win_d         = pick;
                    sh_d          = {20'b0, pick_val};
                    cnt_d         = '0;
                    state_d       = StConv;
                end
            end
            StConv: begin
                sh_d  = shifted;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    ovf_d = |shifted[35:32];
`ifdef BCD_OVF_SAT_EN
                    bcd_d = ovf_d ? 16'h9999 : shifted[31:16];
`else
                    bcd_d = shifted[31:16];
`endif
                    done_id_d = win_q;
                    done_d    = 1'b1;
                    state_d   = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b0;
                grant_d = '0;
                ptr_d   = win_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            ptr_q     <= ID_W'(N_REQ - 1);
            win_q     <= '0;
            cnt_q     <= '0;
            sh_q      <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign done_id = done_id_q;
    assign bcd_out = bcd_q;
    assign ovf     = ovf_q;

endmodule
